// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory access path: op encoding,
// default widths and the access controller state type.
package mem_if_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  // The memory's own op encoding: it writes for as long as op is low.
  localparam logic MEM_OP_READ  = 1'b1;
  localparam logic MEM_OP_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } mem_ctrl_state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between the MEM stage (master) and the
// data-memory access controller (slave).
interface mem_access_ctrl_if #(
  parameter int ADDR_W = mem_if_pkg::ADDR_W,
  parameter int DATA_W = mem_if_pkg::DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_op;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_op, resp_rdata
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, resp_valid, resp_op, resp_rdata
  );

endinterface

// File: rtl/mem_access_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping, so debug
// statistics never read back as a small number after overflow.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count enabled events, holding once every bit is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the combinational data memory. Stores are
// sequenced setup -> one-cycle write strobe -> hold so the memory never
// sees an address or data change while its op pin is low.
module mem_access_ctrl #(
  parameter int ADDR_W = mem_if_pkg::ADDR_W,
  parameter int DATA_W = mem_if_pkg::DATA_W,
  parameter int CNT_W  = mem_if_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.slave  bus,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  import mem_if_pkg::*;

  mem_ctrl_state_t   state;
  mem_ctrl_state_t   state_next;
  logic              accept;
  logic              resp_valid_q;
  logic              resp_op_q;
  logic [DATA_W-1:0] resp_rdata_q;

  assign bus.req_ready  = (state == ST_IDLE) && !reset;
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_op    = resp_op_q;
  assign bus.resp_rdata = resp_rdata_q;

  // State register; reset from any state lands in IDLE on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: reads take one cycle, writes walk setup/pulse/hold.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = (bus.req_op == MEM_OP_READ) ? ST_RD : ST_WR_SETUP;
        end
      end
      ST_RD:       state_next = ST_IDLE;
      ST_WR_SETUP: state_next = ST_WR_PULSE;
      ST_WR_PULSE: state_next = ST_WR_HOLD;
      ST_WR_HOLD:  state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Memory pins are registered so op drops low only for the pulse cycle and
  // address/data move only on the acceptance edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_op         <= MEM_OP_READ;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      mem_op <= (state_next == ST_WR_PULSE) ? MEM_OP_WRITE : MEM_OP_READ;
      if (accept) begin
        mem_address <= bus.req_addr;
        if (bus.req_op == MEM_OP_WRITE) begin
          mem_write_data <= bus.req_wdata;
        end
      end
    end
  end

  // Completion pulse lands in the IDLE cycle after RD or WR_HOLD; read data
  // is captured at the end of RD and left untouched by writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_op_q    <= MEM_OP_READ;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= (state == ST_RD) || (state == ST_WR_HOLD);
      if (state == ST_RD) begin
        resp_op_q    <= MEM_OP_READ;
        resp_rdata_q <= mem_data_out;
      end else if (state == ST_WR_HOLD) begin
        resp_op_q <= MEM_OP_WRITE;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_rd_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (state == ST_RD),
    .count (rd_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_wr_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (state == ST_WR_HOLD),
    .count (wr_count)
  );

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side controller for the combinational data memory: it accepts single-byte load/store requests from the datapath over a valid/ready handshake and drives the memory's `op`/`address`/`write_data` pins. It also captures `data_out`. The memory performs a write for as long as `op`=0 and follows address changes combinationally, so this block sequences every store as setup → one-cycle write strobe → hold. That keeps a changing address or data from ever corrupting a neighbouring location. It sits between the pipeline's MEM stage and the data memory and keeps saturating access counters for debug.

## Interface
Parameters:
- `ADDR_W`, 8, address width (256 locations)
- `DATA_W`, 8, data width
- `CNT_W`, 16, width of the read/write statistics counters

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept; request accepted at edge where `req_valid && req_ready`
- `req_op`  in  1  1 = read, 0 = write (memory's encoding)
- `req_addr`  in  ADDR_W  target address
- `req_wdata`  in  DATA_W  store data (ignored for reads)
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_op`  out  1  op of completed request
- `resp_rdata`  out  DATA_W  read data (valid with `resp_valid && resp_op`)
- `mem_op`  out  1  to memory `op`
- `mem_address`  out  ADDR_W  to memory `address`
- `mem_write_data`  out  DATA_W  to memory `write_data`
- `mem_data_out`  in  DATA_W  from memory `data_out`
- `rd_count`, `wr_count`  out  CNT_W  completed reads / writes, saturating

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- `req_ready` = (state == IDLE) && !`reset`. No request queue; a `req_valid` asserted while busy is held off and is not lost or duplicated.
- Read: IDLE+accept → RD (register `mem_address`=addr, `mem_op`=1). At the end of RD, sample `mem_data_out` into `resp_rdata`, pulse `resp_valid` with `resp_op`=1, return to IDLE, and increment `rd_count`.
- Write: IDLE+accept → WR_SETUP (`mem_address`, `mem_write_data` loaded, `mem_op`=1) → WR_PULSE (`mem_op`=0) → WR_HOLD (`mem_op`=1, address/data unchanged) → IDLE with `resp_valid`=1, `resp_op`=0, `wr_count`+1. `resp_rdata` is unchanged on writes.
- `mem_op` is a register. It is 0 only during WR_PULSE and 1 in every other state and during reset.
- `mem_address` and `mem_write_data` change only on the acceptance edge. They are held through the following IDLE.
- Counters saturate at all-ones and do not wrap.
- Reset in any state:
  - next cycle IDLE, `mem_op`=1, outputs at reset values;
  - a store whose WR_PULSE cycle has completed is committed;
  - reset asserted in WR_SETUP or RD aborts with no memory write and no `resp_valid`.

## Timing
- Reset values: `mem_op`=1, `mem_address`=0, `mem_write_data`=0, `resp_valid`=0, `resp_op`=1, `resp_rdata`=0, `rd_count`=`wr_count`=0. `req_ready`=0 while `reset` is high and 1 in the first cycle after.
- Read: accept at edge k; RD in cycle k+1; `resp_valid` in cycle k+2. Throughput is one read per 2 cycles.
- Write: accept at edge k; SETUP k+1, PULSE k+2, HOLD k+3, `resp_valid` in k+4. Throughput is one write per 4 cycles.
- `resp_valid` coincides with IDLE, so a new request may be accepted in the same cycle as the response.
- Read-after-write to the same address returns the new data, because the write commits in PULSE, before IDLE.

## Structure
- Shared package `mem_if_pkg`:
  - `MEM_OP_READ`=1'b1, `MEM_OP_WRITE`=1'b0;
  - `ADDR_W`/`DATA_W` defaults;
  - state enum `mem_ctrl_state_t`.
- One sub-module: `sat_counter` (parameter width; synchronous reset, increment enable, saturate at all-ones), instantiated twice.

## Test plan
- After reset, memory location 18 preloaded to 8'h03: read addr 18 accepted at edge k → `resp_valid`, `resp_rdata`=8'h03 in cycle k+2; `rd_count`=1.
- Write 8'h05 to addr 1, then read addr 1:
  - `mem_op`=0 for exactly one cycle;
  - `mem_address`=1 and `mem_write_data`=5 stable over SETUP–HOLD;
  - read returns 8'h05; address 2 is unchanged.
- Hold `req_valid` high with alternating ops for 20 cycles → `req_ready` is never high outside IDLE; each accepted request yields exactly one `resp_valid`; responses are in order.
- Assert `reset` during WR_SETUP of a write of 8'hAA to addr 7 → addr 7 reads back its old value; no `resp_valid`; `wr_count`=0.
- Assert `reset` during WR_HOLD → write committed (readback 8'hAA); no `resp_valid`.
- Issue 65,540 writes → `wr_count` stops at 16'hFFFF; `rd_count` is unaffected.
